sha_super_pipelined_block_loader: RTL and testbench

Front-end stage of the super-pipelined SHA-256 core. It accepts 32-bit message words serially over a valid/ready handshake and assembles each group of 16 into a 512-bit block. It issues each block as a single-cycle `valid_o` pulse, together with the starting `HashState`, to round stage 0 (`K=0`) of the preserve-history pipeline. For multi-block messages it holds each subsequent block until the chained digest of the previous block returns from the pipeline tail.

---
 rtl/sha_super_pipelined_block_loader.sv | 121 ++++++++++++
 tb/tb_sha_super_pipelined_block_loader.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha_super_pipelined_block_loader.sv
// rtl/sha_super_pipelined_block_loader.sv - serial word to 512-bit block loader for the SHA-256 pipeline
// Optional macro SHA_LOADER_MIDSTATE_EN adds midstate_i as the first-block starting state.
package sha_loader_pkg;
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    logic [31:0] e;
    logic [31:0] f;
    logic [31:0] g;
    logic [31:0] h;
  } hash_state_t;

  localparam hash_state_t SHA256_IV = '{
    a: 32'h6a09e667, b: 32'hbb67ae85, c: 32'h3c6ef372, d: 32'ha54ff53a,
    e: 32'h510e527f, f: 32'h9b05688c, g: 32'h1f83d9ab, h: 32'h5be0cd19
  };
endpackage

module sha_super_pipelined_block_loader
  import sha_loader_pkg::*;
#(
  parameter hash_state_t IV = SHA256_IV
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       word_i,
  input  logic              word_valid_i,
  input  logic              word_last_i,
  output logic              word_ready_o,
  input  hash_state_t       digest_i,
  input  logic              digest_valid_i,
`ifdef SHA_LOADER_MIDSTATE_EN
  input  hash_state_t       midstate_i,
`endif
  output hash_state_t       state_o,
  output logic [15:0][31:0] W_o,
  output logic              valid_o,
  output logic              newblock_o
);

  typedef enum logic [1:0] {FILL, HOLD, ISSUE} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt;
  logic [15:0][31:0] blk_buf;
  logic              first, chain_pend, last_q;
  hash_state_t       chain_q;
  hash_state_t       first_state;
  logic              xfer;
  logic              issue_go;

`ifdef SHA_LOADER_MIDSTATE_EN
  assign first_state = midstate_i;
`else
  assign first_state = IV;
`endif

  assign word_ready_o = rst && (state_q == FILL);
  assign xfer         = word_valid_i && word_ready_o;

  // Issue registers are loaded on the HOLD exit edge so valid_o is high during ISSUE.
  always_comb begin
    state_d  = state_q;
    issue_go = 1'b0;
    case (state_q)
      FILL: begin
        if (xfer && cnt == 4'd15) state_d = HOLD;
      end
      HOLD: begin
        if (!(chain_pend && !first)) begin
          state_d  = ISSUE;
          issue_go = 1'b1;
        end
      end
      ISSUE:   state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= FILL;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt        <= 4'd0;
      blk_buf    <= '0;
      last_q     <= 1'b0;
      first      <= 1'b1;
      chain_pend <= 1'b0;
      chain_q    <= '0;
      W_o        <= '0;
      state_o    <= '0;
      valid_o    <= 1'b0;
      newblock_o <= 1'b0;
    end else begin
      valid_o <= issue_go;
      if (xfer) begin
        blk_buf[cnt] <= word_i;
        cnt          <= cnt + 4'd1;
        if (cnt == 4'd15) last_q <= word_last_i;
      end
      if (digest_valid_i && chain_pend) begin
        chain_q    <= digest_i;
        chain_pend <= 1'b0;
      end
      // chain_pend is never set when issue_go fires on a chained block, so no digest is lost here.
      if (issue_go) begin
        W_o        <= blk_buf;
        newblock_o <= first;
        state_o    <= first ? first_state : chain_q;
        first      <= last_q;
        chain_pend <= !last_q;
      end
    end
  end

endmodule

// File: tb/tb_sha_super_pipelined_block_loader.sv
// tb/tb_sha_super_pipelined_block_loader.sv - randomized self-checking bench for the SHA block loader
module tb_sha_super_pipelined_block_loader;
  import sha_loader_pkg::*;

  typedef struct {
    logic [15:0][31:0] w;
    bit                last;
    int                acc;
  } blk_t;

  localparam hash_state_t IV_REF = '{
    a: 32'h6a09e667, b: 32'hbb67ae85, c: 32'h3c6ef372, d: 32'ha54ff53a,
    e: 32'h510e527f, f: 32'h9b05688c, g: 32'h1f83d9ab, h: 32'h5be0cd19
  };

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       word_i;
  logic              word_valid_i, word_last_i, word_ready_o;
  hash_state_t       digest_i;
  logic              digest_valid_i;
  hash_state_t       state_o;
  logic [15:0][31:0] W_o;
  logic              valid_o, newblock_o;
  hash_state_t       midstate = IV_REF;

  sha_super_pipelined_block_loader dut (
    .clk(clk), .rst(rst),
    .word_i(word_i), .word_valid_i(word_valid_i), .word_last_i(word_last_i), .word_ready_o(word_ready_o),
    .digest_i(digest_i), .digest_valid_i(digest_valid_i),
`ifdef SHA_LOADER_MIDSTATE_EN
    .midstate_i(midstate),
`endif
    .state_o(state_o), .W_o(W_o), .valid_o(valid_o), .newblock_o(newblock_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: message-level view of what each issued block must carry.
  blk_t              exp_q[$];
  bit                model_first = 1'b1;
  bit                model_pend  = 1'b0;
  hash_state_t       dig_val;
  int                dig_cyc = 0;
  int                issues = 0;
  int                sent = 0;
  int                issue_cyc = 0;
  logic [15:0][31:0] last_w;
  hash_state_t       last_state;
  logic              last_new;

  initial begin : monitor
    blk_t        e;
    hash_state_t es;
    int          ec;
    bit          prev_valid;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && valid_o) begin
        check("valid_back_to_back", prev_valid, 1'b0);
        if (exp_q.size() == 0) begin
          check("unexpected_issue", 1'b1, 1'b0);
        end else begin
          e  = exp_q.pop_front();
          es = model_first ? IV_REF : dig_val;
          ec = e.acc + 2;
          if (!model_first && dig_cyc + 2 > ec) ec = dig_cyc + 2;
          check("issue_W", W_o, e.w);
          check("issue_newblock", newblock_o, model_first);
          check("issue_state", state_o, es);
          check("issue_cycle", cyc, ec);
          model_first = e.last;
          model_pend  = !e.last;
        end
        issues++;
        issue_cyc  = cyc;
        last_w     = W_o;
        last_state = state_o;
        last_new   = newblock_o;
      end
      prev_valid = rst && valid_o;
    end
  end

  function automatic hash_state_t rand_hash();
    hash_state_t h;
    h = '{a: $urandom, b: $urandom, c: $urandom, d: $urandom,
          e: $urandom, f: $urandom, g: $urandom, h: $urandom};
    return h;
  endfunction

  // All driver tasks start and end one time unit after a rising edge.
  task automatic send_word(input logic [31:0] w, input logic last, input int gap, output int acc);
    bit done;
    word_valid_i = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    word_i = w; word_last_i = last; word_valid_i = 1'b1;
    done = 1'b0; acc = -100;
    for (int t = 0; t < 500 && !done; t++) begin
      @(negedge clk);
      if (word_ready_o) begin
        acc  = cyc;
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    word_valid_i = 1'b0;
    if (!done) check("accept_timeout", 1'b0, 1'b1);
  endtask

  task automatic send_block(input logic [15:0][31:0] w, input bit last, input int mode);
    int   acc, gap;
    blk_t e;
    for (int i = 0; i < 16; i++) begin
      gap = (mode == 1) ? 1 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
      send_word(w[i], (i == 15) ? last : 1'($urandom), gap, acc);
    end
    e.w = w; e.last = last; e.acc = acc;
    exp_q.push_back(e);
    sent++;
  endtask

  task automatic pulse_digest(input hash_state_t v);
    digest_i = v; digest_valid_i = 1'b1;
    if (model_pend) begin
      dig_val    = v;
      dig_cyc    = cyc;
      model_pend = 1'b0;
    end
    @(posedge clk); #1;
    digest_valid_i = 1'b0;
  endtask

  task automatic wait_issues(input int n);
    for (int t = 0; t < 3000 && issues < n; t++) @(negedge clk);
    check("issue_count", issues, n);
    @(posedge clk); #1;
  endtask

  task automatic wait_cycle(input int c);
    for (int t = 0; t < 3000 && cyc < c; t++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; word_valid_i = 1'b0; digest_valid_i = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("rst_valid", valid_o, 1'b0);
    check("rst_newblock", newblock_o, 1'b0);
    check("rst_W", W_o, 512'd0);
    check("rst_state", state_o, 256'd0);
    check("rst_ready", word_ready_o, 1'b0);
    exp_q.delete();
    sent        = issues;
    model_first = 1'b1;
    model_pend  = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_rst", word_ready_o, 1'b1);
    @(posedge clk); #1;
  endtask

  logic [15:0][31:0] blk_a, blk_b;
  hash_state_t       hv;
  int                acc, base, nb, dly;

  initial begin
    rst = 1'b0; word_i = '0; word_valid_i = 1'b0; word_last_i = 1'b0;
    digest_i = '0; digest_valid_i = 1'b0;
    do_reset();

    // Single-block "abc"
    blk_a = '0;
    blk_a[0]  = 32'h61626380;
    blk_a[15] = 32'h00000018;
    base = issues;
    send_block(blk_a, 1'b1, 0);
    wait_issues(base + 1);
    check("abc_W0", last_w[0], 32'h61626380);
    check("abc_W15", last_w[15], 32'h00000018);
    check("abc_state_a", last_state.a, 32'h6a09e667);
    check("abc_state_h", last_state.h, 32'h5be0cd19);
    check("abc_newblock", last_new, 1'b1);

    // Two-block message, digest returned 70 cycles after the first issue
    for (int i = 0; i < 16; i++) begin blk_a[i] = $urandom; blk_b[i] = $urandom; end
    base = issues;
    send_block(blk_a, 1'b0, 0);
    wait_issues(base + 1);
    send_block(blk_b, 1'b1, 0);
    wait_cycle(issue_cyc + 70);
    check("hold_ready_low", word_ready_o, 1'b0);
    check("hold_no_issue", issues, base + 1);
    hv = rand_hash();
    hv.a = 32'hDEADBEEF;
    pulse_digest(hv);
    wait_issues(base + 2);
    check("chain_state_a", last_state.a, 32'hDEADBEEF);
    check("chain_newblock", last_new, 1'b0);

    // Digest lands during FILL of the chained block
    for (int i = 0; i < 16; i++) begin blk_a[i] = $urandom; blk_b[i] = $urandom; end
    base = issues;
    send_block(blk_a, 1'b0, 0);
    wait_issues(base + 1);
    hv = rand_hash();
    fork
      send_block(blk_b, 1'b1, 0);
      begin
        repeat (5) begin @(posedge clk); end
        #1;
        pulse_digest(hv);
      end
    join
    wait_issues(base + 2);
    check("fill_digest_state", last_state, hv);

    // Stray digest with nothing pending
    pulse_digest(rand_hash());
    for (int i = 0; i < 16; i++) blk_a[i] = $urandom;
    base = issues;
    send_block(blk_a, 1'b1, 0);
    wait_issues(base + 1);
    check("stray_state_iv", last_state, IV_REF);

    // Reset after 7 words of a block
    for (int i = 0; i < 7; i++) send_word($urandom, 1'b0, 0, acc);
    do_reset();
    for (int i = 0; i < 16; i++) blk_a[i] = $urandom;
    base = issues;
    send_block(blk_a, 1'b1, 0);
    wait_issues(base + 1);
    check("post_rst_W0", last_w[0], blk_a[0]);
    check("post_rst_newblock", last_new, 1'b1);

    // word_valid_i toggling every other cycle
    for (int i = 0; i < 16; i++) blk_a[i] = $urandom;
    base = issues;
    send_block(blk_a, 1'b1, 1);
    wait_issues(base + 1);
    check("toggle_W", last_w, blk_a);

    // Random multi-block messages with random word gaps and digest delays
    for (int m = 0; m < 8; m++) begin
      nb = $urandom_range(1, 3);
      for (int b = 0; b < nb; b++) begin
        for (int i = 0; i < 16; i++) blk_a[i] = $urandom;
        base = sent;
        dly  = $urandom_range(1, 40);
        hv   = rand_hash();
        fork
          send_block(blk_a, b == nb - 1, 2);
          if (b > 0) begin
            for (int t = 0; t < 3000 && issues < base; t++) @(negedge clk);
            repeat (dly) begin @(posedge clk); end
            #1;
            pulse_digest(hv);
          end
        join
      end
    end
    wait_issues(sent);
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
